// File: rtl/kv_key_read_fsm.sv
// rtl/kv_key_read_fsm.sv - key-vault read client sequencer streaming one KV entry into a crypto client register
// Optional: KV_READ_ZEROIZE_ON_ERR_EN adds a CLEAR state that wipes the client after a KV read error.
module kv_key_read_fsm #(
  parameter int DATA_WIDTH   = 384,
  parameter int ENTRY_ADDR_W = 5,
  localparam int NUM_DWORDS  = DATA_WIDTH / 32,
  localparam int OFFSET_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    zeroize,
  input  logic                    read_start,
  input  logic [ENTRY_ADDR_W-1:0] read_entry_sel,
  output logic [ENTRY_ADDR_W-1:0] kv_read_entry,
  output logic [OFFSET_W-1:0]     kv_read_offset,
  input  logic [31:0]             kv_rd_data,
  input  logic                    kv_rd_error,
  input  logic                    client_ready,
  output logic                    client_write_en,
  output logic [OFFSET_W-1:0]     client_write_offset,
  output logic [31:0]             client_write_data,
  output logic                    read_busy,
  output logic                    read_done,
  output logic                    read_error
);

  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(NUM_DWORDS - 1);
  localparam logic [OFFSET_W-1:0] ONE  = OFFSET_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPTURE,
`ifdef KV_READ_ZEROIZE_ON_ERR_EN
    S_CLEAR,
`endif
    S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [OFFSET_W-1:0]     cnt, cnt_nxt;
  logic [ENTRY_ADDR_W-1:0] entry, entry_nxt;
  logic                    error_nxt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      cnt        <= '0;
      entry      <= '0;
      read_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      entry      <= entry_nxt;
      read_error <= error_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    cnt_nxt             = cnt;
    entry_nxt           = entry;
    error_nxt           = read_error;
    kv_read_entry       = '0;
    kv_read_offset      = '0;
    client_write_en     = 1'b0;
    client_write_offset = '0;
    client_write_data   = '0;
    read_done           = 1'b0;

    case (state)
      S_IDLE: begin
        if (read_start) begin
          entry_nxt = read_entry_sel;
          error_nxt = 1'b0;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        kv_read_entry  = entry;
        kv_read_offset = cnt;
        state_nxt      = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Address stays on the KV port so a stalled dword remains valid.
        kv_read_entry  = entry;
        kv_read_offset = cnt;
        if (kv_rd_error) begin
          error_nxt = 1'b1;
`ifdef KV_READ_ZEROIZE_ON_ERR_EN
          cnt_nxt   = '0;
          state_nxt = S_CLEAR;
`else
          state_nxt = S_DONE;
`endif
        end else if (client_ready) begin
          client_write_en     = 1'b1;
          client_write_offset = LAST - cnt;
          client_write_data   = kv_rd_data;
          if (cnt == LAST) begin
            state_nxt = S_DONE;
          end else begin
            cnt_nxt   = cnt + ONE;
            state_nxt = S_REQ;
          end
        end
      end
`ifdef KV_READ_ZEROIZE_ON_ERR_EN
      S_CLEAR: begin
        if (client_ready) begin
          client_write_en     = 1'b1;
          client_write_offset = cnt;
          if (cnt == LAST) state_nxt = S_DONE;
          else             cnt_nxt   = cnt + ONE;
        end
      end
`endif
      S_DONE: begin
        read_done = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Zeroize overrides everything except the sticky error flag.
    if (zeroize) begin
      state_nxt           = S_IDLE;
      cnt_nxt             = '0;
      entry_nxt           = '0;
      error_nxt           = read_error;
      client_write_en     = 1'b0;
      client_write_offset = '0;
      client_write_data   = '0;
      read_done           = 1'b0;
    end
  end

  assign read_busy = (state != S_IDLE);

endmodule

// File: tb/tb_kv_key_read_fsm.sv
// tb/tb_kv_key_read_fsm.sv - self-checking bench for kv_key_read_fsm against a dword-sequence reference model
module tb_kv_key_read_fsm;
  localparam int N = 12;
`ifdef KV_READ_ZEROIZE_ON_ERR_EN
  localparam bit ZCLR = 1'b1;
`else
  localparam bit ZCLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        zeroize = 1'b0;
  logic        read_start = 1'b0;
  logic [4:0]  read_entry_sel = '0;
  logic [4:0]  kv_read_entry;
  logic [3:0]  kv_read_offset;
  logic [31:0] kv_rd_data = '0;
  logic        kv_rd_error = 1'b0;
  logic        client_ready = 1'b1;
  logic        client_write_en;
  logic [3:0]  client_write_offset;
  logic [31:0] client_write_data;
  logic        read_busy, read_done, read_error;

  kv_key_read_fsm dut (
    .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .read_start(read_start),
    .read_entry_sel(read_entry_sel), .kv_read_entry(kv_read_entry),
    .kv_read_offset(kv_read_offset), .kv_rd_data(kv_rd_data), .kv_rd_error(kv_rd_error),
    .client_ready(client_ready), .client_write_en(client_write_en),
    .client_write_offset(client_write_offset), .client_write_data(client_write_data),
    .read_busy(read_busy), .read_done(read_done), .read_error(read_error)
  );

  always #5 clk = ~clk;

  logic [31:0] kv_mem [0:31][0:15];
  int          err_entry = -1;
  int          err_off = -1;
  int          cyc = 0;
  logic [35:0] wq[$];
  logic [35:0] eq[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;
  int          idle_data_bad = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // KV port model: one-cycle read latency, error on the selected (entry, offset).
  always @(posedge clk) begin
    kv_rd_data  <= kv_mem[kv_read_entry][kv_read_offset];
    kv_rd_error <= (int'(kv_read_entry) == err_entry) && (int'(kv_read_offset) == err_off);
    cyc         <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_b) begin
      if (client_write_en) wq.push_back({client_write_offset, client_write_data});
      else if (client_write_data !== 32'd0) idle_data_bad++;
      if (read_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = read_error;
      end
    end
  end

  // Expected client writes: nw KV dwords big-endian swizzled, then an optional full wipe.
  function automatic void model(input int e, input int nw, input bit clr);
    eq.delete();
    for (int i = 0; i < nw; i++) eq.push_back({4'(N - 1 - i), kv_mem[e][i]});
    if (clr) for (int j = 0; j < N; j++) eq.push_back({4'(j), 32'd0});
  endfunction

  function automatic int first_diff();
    if (eq.size() != wq.size()) return 999;
    for (int i = 0; i < eq.size(); i++) if (eq[i] !== wq[i]) return i;
    return -1;
  endfunction

  function automatic void fill(input int e, input bit idx_data);
    for (int i = 0; i < 16; i++) kv_mem[e][i] = idx_data ? 32'(i) : $urandom;
  endfunction

  task automatic kick(input int e, output int c0);
    wq.delete();
    done_cnt = 0;
    read_entry_sel = 5'(e);
    read_start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    read_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input bit rnd_ready);
    for (int i = 0; i < limit && read_busy; i++) begin
      if (rnd_ready) client_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    client_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({read_busy, read_done, read_error, client_write_en, kv_read_offset, kv_read_entry,
         client_write_offset, client_write_data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b done=%b err=%b wen=%b, required all 0",
                         read_busy, read_done, read_error, client_write_en);
    end
    @(posedge clk); #1; rst_b = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (read_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b required 0", read_busy); end
  endtask

  task automatic test_basic();
    int c0;
    fill(7, 1'b1);
    kick(7, c0);
    n_cmp++;
    if (read_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: %b required 1", read_busy); end
    wait_idle(100, 1'b0);
    model(7, N, 1'b0);
    n_cmp++;
    if (first_diff() != -1) begin n_fail++; $display("FAIL basic_writes: %0d writes, diff at %0d, required %0d", wq.size(), first_diff(), eq.size()); end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != c0 + 2*N + 1) begin
      n_fail++; $display("FAIL basic_done: count=%0d at T+%0d, required 1 at T+%0d", done_cnt, done_cyc - c0, 2*N + 1);
    end
    n_cmp++;
    if (done_err !== 1'b0) begin n_fail++; $display("FAIL basic_error: %b required 0", done_err); end
  endtask

  task automatic test_stall();
    int c0;
    fill(3, 1'b0);
    kick(3, c0);
    while (cyc < c0 + 10) begin @(posedge clk); #1; end
    client_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (kv_read_offset !== 4'd4 || client_write_en !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: offset=%0d wen=%b, required 4 and 0", kv_read_offset, client_write_en);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    client_ready = 1'b1;
    wait_idle(100, 1'b0);
    model(3, N, 1'b0);
    n_cmp++;
    if (first_diff() != -1) begin n_fail++; $display("FAIL stall_writes: %0d writes, diff at %0d", wq.size(), first_diff()); end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != c0 + 2*N + 4) begin
      n_fail++; $display("FAIL stall_done: count=%0d at T+%0d, required 1 at T+%0d", done_cnt, done_cyc - c0, 2*N + 4);
    end
  endtask

  task automatic test_error();
    int c0;
    fill(9, 1'b0);
    err_entry = 9; err_off = 5;
    kick(9, c0);
    wait_idle(100, 1'b0);
    err_entry = -1;
    model(9, 5, ZCLR);
    n_cmp++;
    if (first_diff() != -1) begin n_fail++; $display("FAIL error_writes: %0d writes, diff at %0d, required %0d", wq.size(), first_diff(), eq.size()); end
    n_cmp++;
    if (done_cnt != 1 || done_err !== 1'b1 || done_cyc != c0 + 13 + (ZCLR ? N : 0)) begin
      n_fail++; $display("FAIL error_done: count=%0d err=%b at T+%0d, required 1, 1 at T+%0d", done_cnt, done_err, done_cyc - c0, 13 + (ZCLR ? N : 0));
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (read_error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: %b required 1", read_error); end
  endtask

  task automatic test_zeroize();
    int c0;
    fill(12, 1'b0);
    kick(12, c0);
    n_cmp++;
    if (read_error !== 1'b0) begin n_fail++; $display("FAIL error_clear_on_start: %b required 0", read_error); end
    while (cyc < c0 + 14) begin @(posedge clk); #1; end
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    n_cmp++;
    if (read_busy !== 1'b0 || kv_read_offset !== 4'd0 || kv_read_entry !== 5'd0) begin
      n_fail++; $display("FAIL zeroize_idle: busy=%b offset=%0d entry=%0d, required 0", read_busy, kv_read_offset, kv_read_entry);
    end
    repeat (4) @(posedge clk); #1;
    model(12, 6, 1'b0);
    n_cmp++;
    if (first_diff() != -1 || done_cnt != 0) begin
      n_fail++; $display("FAIL zeroize_abort: %0d writes, %0d done, required 6 writes, 0 done", wq.size(), done_cnt);
    end
    kick(12, c0);
    wait_idle(100, 1'b0);
    model(12, N, 1'b0);
    n_cmp++;
    if (first_diff() != -1 || done_cnt != 1 || done_cyc != c0 + 2*N + 1) begin
      n_fail++; $display("FAIL zeroize_restart: %0d writes, done=%0d at T+%0d, required %0d writes at T+%0d", wq.size(), done_cnt, done_cyc - c0, N, 2*N + 1);
    end
  endtask

  task automatic test_busy_start();
    int c0;
    fill(20, 1'b0);
    fill(21, 1'b0);
    kick(20, c0);
    repeat (3) @(posedge clk); #1;
    read_entry_sel = 5'd21; read_start = 1'b1;
    @(posedge clk); #1;
    read_start = 1'b0;
    wait_idle(100, 1'b0);
    model(20, N, 1'b0);
    n_cmp++;
    if (first_diff() != -1 || done_cnt != 1 || done_cyc != c0 + 2*N + 1) begin
      n_fail++; $display("FAIL busy_start_ignored: %0d writes diff at %0d, done=%0d", wq.size(), first_diff(), done_cnt);
    end
    read_start = 1'b1; zeroize = 1'b1;
    @(posedge clk); #1;
    read_start = 1'b0; zeroize = 1'b0;
    n_cmp++;
    if (read_busy !== 1'b0) begin n_fail++; $display("FAIL start_zeroize_same_cycle: busy=%b required 0", read_busy); end
  endtask

  task automatic test_async_reset();
    int c0;
    kick(7, c0);
    repeat (6) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    n_cmp++;
    if ({read_busy, read_done, read_error, client_write_en, kv_read_offset, kv_read_entry,
         client_write_offset, client_write_data} !== '0) begin
      n_fail++; $display("FAIL async_reset: busy=%b wen=%b offset=%0d entry=%0d, required all 0",
                         read_busy, client_write_en, kv_read_offset, kv_read_entry);
    end
    @(posedge clk); #1; rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int c0, e, ep;
    for (int it = 0; it < 24; it++) begin
      e = $urandom_range(0, 31);
      fill(e, 1'b0);
      ep = ($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1;
      err_entry = (ep >= 0) ? e : -1;
      err_off = ep;
      kick(e, c0);
      wait_idle(400, 1'b1);
      n_cmp++;
      if (read_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout[%0d]: still busy", it); end
      model(e, (ep >= 0) ? ep : N, (ep >= 0) && ZCLR);
      n_cmp++;
      if (first_diff() != -1 || done_cnt != 1 || done_err !== (ep >= 0)) begin
        n_fail++; $display("FAIL b2b[%0d]: entry=%0d errpos=%0d writes=%0d diff=%0d done=%0d err=%b, required %0d writes err=%b",
                           it, e, ep, wq.size(), first_diff(), done_cnt, done_err, eq.size(), ep >= 0);
      end
    end
    err_entry = -1;
    n_cmp++;
    if (idle_data_bad != 0) begin n_fail++; $display("FAIL idle_data_zero: %0d cycles nonzero, required 0", idle_data_bad); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_zeroize();
    test_busy_start();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
